exmem_wb_responder: RTL and testbench

- Wishbone slave that sits behind the wishbone arbiter at address window 0x3800_0000. It answers reads and writes from the FIR, QS and MM DMA masters.
- Models external memory: a word-addressed backing array with a fixed access delay (READ_DELAY).
- Adds a one-line read prefetch buffer so sequential DMA reads within a line complete in 1 cycle.
- Writes go through to the array and update the buffered line when they hit it.

---
 rtl/exmem_wb_responder.sv | 216 +++++++++++++++++++++
 tb/tb_exmem_wb_responder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/exmem_wb_responder.sv
// ============================================================================
// exmem_wb_responder: Wishbone external-memory model, one-line read prefetch.
// Rev 1.0
// ============================================================================
`default_nettype none

module exmem_wb_responder #(
    parameter int ADDR_BITS  = 10,
    parameter int READ_DELAY = 10,
    parameter int LINE_WORDS = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] hit_cnt_o,
    output logic [15:0] miss_cnt_o,
    output logic        busy_o
);

    localparam int OFF_BITS = $clog2(LINE_WORDS);
    localparam int TAG_BITS = ADDR_BITS - OFF_BITS;
    localparam int CNT_BITS = $clog2(READ_DELAY + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    localparam logic [CNT_BITS-1:0] C_DELAY   = CNT_BITS'(READ_DELAY);
    localparam logic [CNT_BITS-1:0] C_ONE     = CNT_BITS'(1);
    localparam logic [15:0]         C_CNT_MAX = 16'hFFFF;

    logic [1:0]           state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic [31:0]          dat_q, dat_d;
    logic [15:0]          hit_q, hit_d;
    logic [15:0]          miss_q, miss_d;
    logic                 line_valid_q;
    logic [TAG_BITS-1:0]  line_tag_q;
    logic [31:0]          line_q [LINE_WORDS];
    logic [ADDR_BITS-1:0] addr_q;
    logic [3:0]           sel_q;
    logic [31:0]          wdat_q;
    logic [31:0]          mem_q [2**ADDR_BITS];

    logic [ADDR_BITS-1:0] w_waddr;
    logic [TAG_BITS-1:0]  w_tag_in;
    logic [OFF_BITS-1:0]  w_off_in;
    logic [TAG_BITS-1:0]  w_rtag;
    logic [OFF_BITS-1:0]  w_roff;
    logic                 w_req;
    logic                 w_hit_in;
    logic                 w_last;
    logic                 w_fill;
    logic                 w_commit;
    logic                 w_unused_adr;

    assign w_waddr      = wbs_adr_i[ADDR_BITS+1:2];
    assign w_tag_in     = w_waddr[ADDR_BITS-1:OFF_BITS];
    assign w_off_in     = w_waddr[OFF_BITS-1:0];
    assign w_rtag       = addr_q[ADDR_BITS-1:OFF_BITS];
    assign w_roff       = addr_q[OFF_BITS-1:0];
    assign w_req        = (state_q == S_IDLE) && wbs_stb_i && wbs_cyc_i && !ack_q;
    assign w_hit_in     = line_valid_q && (line_tag_q == w_tag_in);
    assign w_last       = (cnt_q == C_ONE);
    assign w_unused_adr = ^{wbs_adr_i[31:ADDR_BITS+2], wbs_adr_i[1:0]};

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_req && wbs_we_i) begin
                    state_d = S_WRITE;
                end else if (w_req && !w_hit_in) begin
                    state_d = S_FILL;
                end
            end
            S_FILL, S_WRITE: begin
                if (!wbs_cyc_i || w_last) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An abort (cyc dropped) takes priority over completion in the same cycle.
    always_comb begin
        ack_d    = 1'b0;
        dat_d    = 32'd0;
        cnt_d    = cnt_q;
        hit_d    = hit_q;
        miss_d   = miss_q;
        w_fill   = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    if (wbs_we_i) begin
                        cnt_d = C_DELAY;
                    end else if (w_hit_in) begin
                        ack_d = 1'b1;
                        dat_d = line_q[w_off_in];
                        hit_d = (hit_q == C_CNT_MAX) ? hit_q : hit_q + 16'd1;
                    end else begin
                        cnt_d  = C_DELAY;
                        miss_d = (miss_q == C_CNT_MAX) ? miss_q : miss_q + 16'd1;
                    end
                end
            end
            S_FILL: begin
                if (!wbs_cyc_i) begin
                    cnt_d = '0;
                end else if (w_last) begin
                    cnt_d  = '0;
                    w_fill = 1'b1;
                    ack_d  = 1'b1;
                    dat_d  = mem_q[addr_q];
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            S_WRITE: begin
                if (!wbs_cyc_i) begin
                    cnt_d = '0;
                end else if (w_last) begin
                    cnt_d    = '0;
                    w_commit = 1'b1;
                    ack_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - C_ONE;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            cnt_q        <= '0;
            ack_q        <= 1'b0;
            dat_q        <= 32'd0;
            hit_q        <= 16'd0;
            miss_q       <= 16'd0;
            line_valid_q <= 1'b0;
            line_tag_q   <= '0;
            addr_q       <= '0;
            sel_q        <= 4'd0;
            wdat_q       <= 32'd0;
            for (int i = 0; i < LINE_WORDS; i++) begin
                line_q[i] <= 32'd0;
            end
        end else begin
            cnt_q  <= cnt_d;
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            hit_q  <= hit_d;
            miss_q <= miss_d;
            if (w_req) begin
                addr_q <= w_waddr;
                sel_q  <= wbs_sel_i;
                wdat_q <= wbs_dat_i;
            end
            if (w_fill) begin
                line_valid_q <= 1'b1;
                line_tag_q   <= w_rtag;
                for (int i = 0; i < LINE_WORDS; i++) begin
                    line_q[i] <= mem_q[{w_rtag, OFF_BITS'(i)}];
                end
            end else if (w_commit && line_valid_q && (line_tag_q == w_rtag)) begin
                for (int b = 0; b < 4; b++) begin
                    if (sel_q[b]) begin
                        line_q[w_roff][8*b +: 8] <= wdat_q[8*b +: 8];
                    end
                end
            end
        end
    end

    // Backing array has no reset; contents survive wb_rst_n.
    always_ff @(posedge wb_clk_i) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (sel_q[b]) begin
                    mem_q[addr_q][8*b +: 8] <= wdat_q[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;
    assign hit_cnt_o  = hit_q;
    assign miss_cnt_o = miss_q;
    assign busy_o     = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_exmem_wb_responder.sv
// ============================================================================
// tb_exmem_wb_responder: directed + random bench with a word-array memory model.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_exmem_wb_responder;

    localparam int RD   = 10;
    localparam int NLAT = RD + 1;

    logic        clk;
    logic        rst_n;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] dat_i, adr;
    logic        ack;
    logic [31:0] dat_o;
    logic [15:0] hit_cnt, miss_cnt;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model: plain word array plus the address range of the last filled line.
    logic [31:0] ref_mem [1024];
    bit          ref_valid;
    int          ref_line;
    int          ref_hit, ref_miss;

    exmem_wb_responder #(.ADDR_BITS(10), .READ_DELAY(RD), .LINE_WORDS(4)) dut (
        .wb_clk_i  (clk),
        .wb_rst_n  (rst_n),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (dat_i),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (dat_o),
        .hit_cnt_o (hit_cnt),
        .miss_cnt_o(miss_cnt),
        .busy_o    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ref_valid = 0;
        ref_hit   = 0;
        ref_miss  = 0;
    endtask

    task automatic model(input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int elat, output logic [31:0] edat);
        int word = int'(a[11:2]);
        int line = word / 4;
        if (w) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) ref_mem[word][8*b +: 8] = d[8*b +: 8];
            elat = NLAT;
            edat = 32'd0;
        end else if (ref_valid && ref_line == line) begin
            elat = 1;
            edat = ref_mem[word];
            if (ref_hit < 65535) ref_hit++;
        end else begin
            elat = NLAT;
            edat = ref_mem[word];
            if (ref_miss < 65535) ref_miss++;
            ref_valid = 1;
            ref_line  = line;
        end
    endtask

    // kind: 0 normal, 1 drop cyc in cycle 'at', 2 assert reset in cycle 'at'
    task automatic bus(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input int kind, input int at,
                       output int lat, output logic [31:0] rd, output logic ack_after,
                       output logic busy_after, output logic leak);
        bit done = 0;
        int lim  = (kind == 0) ? 40 : 25;
        lat = 0; rd = 32'd0; leak = 1'b0; busy_after = 1'b1;
        @(posedge clk); #1;
        stb = 1'b1; cyc = 1'b1; we = w; sel = s; adr = a; dat_i = d;
        @(posedge clk);
        for (int k = 1; k <= lim && !done; k++) begin
            #1;
            if (kind == 1 && k == at) begin cyc = 1'b0; stb = 1'b0; end
            if (kind == 2 && k == at) begin rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; end
            if (kind == 2 && k == at + 2) rst_n = 1'b1;
            @(negedge clk);
            if (ack) begin lat = k; rd = dat_o; done = 1; end
            else if (dat_o !== 32'd0) leak = 1'b1;
            if (k == at + 1) busy_after = busy;
            @(posedge clk);
        end
        #1;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        ack_after = ack;
    endtask

    task automatic txn(input string tag, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd);
        int          elat;
        logic [31:0] edat;
        logic        aa, ba, lk;
        model(w, s, a, d, elat, edat);
        bus(w, s, a, d, 0, 0, lat, rd, aa, ba, lk);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_dat"}, rd, edat);
        chk({tag, "_ack1cyc"}, {31'd0, aa}, 32'd0);
        chk({tag, "_datidle"}, {31'd0, lk}, 32'd0);
        chk({tag, "_hits"}, {16'd0, hit_cnt}, ref_hit);
        chk({tag, "_miss"}, {16'd0, miss_cnt}, ref_miss);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        aa, ba, lk;
        logic [31:0] base = 32'h3800_0000;

        rst_n = 1'b0; stb = 1'b1; cyc = 1'b1; we = 1'b0;
        sel = 4'hF; dat_i = 32'd0; adr = 32'h3800_0010;
        model_reset();

        // 1. reset with request lines asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
        chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
        @(posedge clk); #1;
        stb = 1'b0; cyc = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_ack", {31'd0, ack}, 32'd0);
        end

        // 2. write-through then miss read
        txn("wr10", 1'b1, 4'hF, base + 32'h10, 32'hDEAD_BEEF, lat, rd);
        chk("wr10_lat11", lat, 32'd11);
        txn("pre14", 1'b1, 4'hF, base + 32'h14, 32'd1, lat, rd);
        txn("pre18", 1'b1, 4'hF, base + 32'h18, 32'd2, lat, rd);
        txn("pre1c", 1'b1, 4'hF, base + 32'h1C, 32'd3, lat, rd);
        txn("pre20", 1'b1, 4'hF, base + 32'h20, 32'h0000_55AA, lat, rd);
        txn("pre40", 1'b1, 4'hF, base + 32'h40, 32'hCAFE_0040, lat, rd);
        txn("rd10", 1'b0, 4'hF, base + 32'h10, 32'd0, lat, rd);
        chk("rd10_const", rd, 32'hDEAD_BEEF);
        chk("rd10_miss1", {16'd0, miss_cnt}, 32'd1);

        // 3. sequential hits, then a new line
        txn("rd14", 1'b0, 4'hF, base + 32'h14, 32'd0, lat, rd);
        chk("rd14_lat1", lat, 32'd1);
        txn("rd18", 1'b0, 4'hF, base + 32'h18, 32'd0, lat, rd);
        txn("rd1c", 1'b0, 4'hF, base + 32'h1C, 32'd0, lat, rd);
        chk("rd1c_const", rd, 32'd3);
        chk("hit3", {16'd0, hit_cnt}, 32'd3);
        txn("rd20", 1'b0, 4'hF, base + 32'h20, 32'd0, lat, rd);
        chk("rd20_miss2", {16'd0, miss_cnt}, 32'd2);

        // 4. byte-lane write into the buffered line
        txn("rd10b", 1'b0, 4'hF, base + 32'h10, 32'd0, lat, rd);
        txn("wrlane", 1'b1, 4'b0010, base + 32'h10, 32'h0000_AB00, lat, rd);
        txn("rd10c", 1'b0, 4'hF, base + 32'h10, 32'd0, lat, rd);
        chk("rd10c_lat1", lat, 32'd1);
        chk("rd10c_const", rd, 32'hDEAD_ABEF);

        // 5. aborted write leaves the array untouched
        bus(1'b1, 4'hF, base + 32'h40, 32'h1234_5678, 1, 5, lat, rd, aa, ba, lk);
        chk("abort_noack", lat, 32'd0);
        chk("abort_busy", {31'd0, ba}, 32'd0);
        txn("rd40", 1'b0, 4'hF, base + 32'h40, 32'd0, lat, rd);
        chk("rd40_const", rd, 32'hCAFE_0040);

        // 6. reset during a miss
        bus(1'b0, 4'hF, base + 32'h10, 32'd0, 2, 4, lat, rd, aa, ba, lk);
        chk("rstmid_noack", lat, 32'd0);
        model_reset();
        chk("rstmid_miss0", {16'd0, miss_cnt}, 32'd0);
        txn("rd10d", 1'b0, 4'hF, base + 32'h10, 32'd0, lat, rd);
        chk("rd10d_miss1", {16'd0, miss_cnt}, 32'd1);
        chk("rd10d_const", rd, 32'hDEAD_ABEF);

        // Random traffic over 32 words: preload, then mixed reads/writes.
        for (int i = 0; i < 32; i++)
            txn("rpre", 1'b1, 4'hF, base + 32'(i * 4), $urandom, lat, rd);
        for (int i = 0; i < 60; i++) begin
            logic        w = ($urandom_range(0, 9) < 3);
            logic [3:0]  s = 4'($urandom_range(0, 15));
            logic [31:0] a = base + 32'($urandom_range(0, 31) * 4);
            txn("rnd", w, s, a, $urandom, lat, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
